// File: rtl/i2c_target.sv
// i2c_target: I2C target engine answering a fixed 7-bit address. Write bytes
// are delivered on RX_DATA/RX_VALID; read bytes are fetched from fabric via
// TX_REQ/TX_DATA. SCL/SDA are oversampled on BUS_CLK and driven open-drain.
// Optional clock stretching on read-byte fetch: define I2C_TARGET_STRETCH_EN.
module i2c_target #(
  parameter logic [6:0]  ADDR   = 7'h20,
  parameter int unsigned FILTER = 3
) (
  input  logic       BUS_CLK,
  input  logic       BUS_RST_N,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_FIRST,
  input  logic [7:0] TX_DATA,
  output logic       TX_REQ,
  input  logic       TX_ACK,
  output logic       STOP,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  // Index 0 = SCL, index 1 = SDA throughout the input path.
  logic [1:0]       meta_q, sync_q, filt_q, prev_q;
  logic [CNT_W-1:0] flt_cnt_q [2];
  logic             scl_rise_q, scl_fall_q, start_q, stop_q;

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic             full_q, full_d;
  logic             rw_q, rw_d;
  logic             first_arm_q, first_arm_d;
  logic             sda_oe_q, sda_oe_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_first_q, rx_first_d;
  logic             tx_req_q, tx_req_d;
  logic             stop_pulse_q, stop_pulse_d;
  logic             busy_q, busy_d;
  logic             next_tx, load_tx;
  logic             sda_s;
  logic [7:0]       byte_nx;

`ifdef I2C_TARGET_STRETCH_EN
  localparam int unsigned REL_W = 5;
  logic             scl_oe_q, scl_oe_d;
  logic             hold_q, hold_d;
  logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;
  logic             ack_seen_q, ack_seen_d;
`else
  logic             unused_tx_ack;
  assign unused_tx_ack = TX_ACK;
`endif

  // Two-flop synchronizer; idle bus reads as high.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {i2c_sda, i2c_scl};
      sync_q <= meta_q;
    end
  end

  // Glitch filter: follow the synchronized level after FILTER equal samples.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == CNT_W'(FILTER - 1)) begin
          filt_q[i]    <= sync_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Registered SCL edges and START/STOP conditions (SDA edge with SCL high).
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      prev_q     <= 2'b11;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      prev_q     <= filt_q;
      scl_rise_q <= filt_q[0] & ~prev_q[0];
      scl_fall_q <= ~filt_q[0] & prev_q[0];
      start_q    <= ~filt_q[1] & prev_q[1] & filt_q[0] & prev_q[0];
      stop_q     <= filt_q[1] & ~prev_q[1] & filt_q[0] & prev_q[0];
    end
  end

  assign sda_s   = filt_q[1];
  assign byte_nx = {shift_q, sda_s};

  // Protocol state register and output registers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      full_q       <= 1'b0;
      rw_q         <= 1'b0;
      first_arm_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      tx_req_q     <= 1'b0;
      stop_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_q     <= 1'b0;
      hold_q       <= 1'b0;
      rel_cnt_q    <= '0;
      ack_seen_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      full_q       <= full_d;
      rw_q         <= rw_d;
      first_arm_q  <= first_arm_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      tx_req_q     <= tx_req_d;
      stop_pulse_q <= stop_pulse_d;
      busy_q       <= busy_d;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_q     <= scl_oe_d;
      hold_q       <= hold_d;
      rel_cnt_q    <= rel_cnt_d;
      ack_seen_q   <= ack_seen_d;
`endif
    end
  end

  // Next-state and output logic; START/STOP override bit processing.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    full_d       = full_q;
    rw_d         = rw_q;
    first_arm_d  = first_arm_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = 1'b0;
    tx_req_d     = 1'b0;
    stop_pulse_d = 1'b0;
    next_tx      = 1'b0;
    load_tx      = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
    scl_oe_d     = scl_oe_q;
    hold_d       = hold_q;
    rel_cnt_d    = rel_cnt_q;
    ack_seen_d   = ack_seen_q;
    if (rel_cnt_q != '0) begin
      rel_cnt_d = rel_cnt_q - 1'b1;
      if (rel_cnt_q == REL_W'(1)) scl_oe_d = 1'b0;
    end
`endif

    if (start_q) begin
      state_d     = S_ADDR;
      bit_cnt_d   = '0;
      full_d      = 1'b0;
      first_arm_d = 1'b0;
      sda_oe_d    = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_d    = 1'b0;
      hold_d      = 1'b0;
      rel_cnt_d   = '0;
`endif
    end else if (stop_q) begin
      state_d      = S_IDLE;
      stop_pulse_d = 1'b1;
      full_d       = 1'b0;
      sda_oe_d     = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      scl_oe_d     = 1'b0;
      hold_d       = 1'b0;
      rel_cnt_d    = '0;
`endif
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise_q) begin
            shift_d   = byte_nx[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d   = sda_s;
              full_d = 1'b1;
              if (shift_q != ADDR) begin
                state_d = S_IGNORE;
                full_d  = 1'b0;
              end
            end
          end else if (scl_fall_q && full_q) begin
            sda_oe_d = 1'b1;
            full_d   = 1'b0;
            state_d  = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (!rw_q) begin
            if (scl_fall_q) begin
              sda_oe_d    = 1'b0;
              bit_cnt_d   = '0;
              first_arm_d = 1'b1;
              state_d     = S_WR_DATA;
            end
          end else begin
            if (scl_rise_q) tx_req_d = 1'b1;
            if (scl_fall_q) next_tx = 1'b1;
          end
        end
        S_WR_DATA: begin
          if (scl_rise_q) begin
            shift_d   = byte_nx[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = byte_nx;
              rx_valid_d  = 1'b1;
              rx_first_d  = first_arm_q;
              first_arm_d = 1'b0;
              full_d      = 1'b1;
            end
          end else if (scl_fall_q && full_q) begin
            sda_oe_d = 1'b1;
            full_d   = 1'b0;
            state_d  = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall_q) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
`ifdef I2C_TARGET_STRETCH_EN
          if (hold_q) begin
            if (ack_seen_q || TX_ACK) begin
              load_tx   = 1'b1;
              hold_d    = 1'b0;
              rel_cnt_d = REL_W'(FILTER + 2);
            end
          end else
`endif
          if (scl_fall_q) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              full_d   = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise_q) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              full_d   = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_IGNORE;
            end
          end else if (scl_fall_q && full_q) begin
            next_tx = 1'b1;
          end
        end
        default: ;
      endcase

      // Fetch the next read byte on the fall that ends an acknowledged bit.
      if (next_tx) begin
`ifdef I2C_TARGET_STRETCH_EN
        if (ack_seen_q || TX_ACK) begin
          load_tx = 1'b1;
        end else begin
          hold_d    = 1'b1;
          scl_oe_d  = 1'b1;
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
          full_d    = 1'b0;
          state_d   = S_RD_DATA;
        end
`else
        load_tx = 1'b1;
`endif
      end

      if (load_tx) begin
        shift_d   = TX_DATA[6:0];
        sda_oe_d  = ~TX_DATA[7];
        bit_cnt_d = '0;
        full_d    = 1'b0;
        state_d   = S_RD_DATA;
      end
    end

`ifdef I2C_TARGET_STRETCH_EN
    if (start_q || stop_q || tx_req_d) ack_seen_d = 1'b0;
    else if (TX_ACK)                   ack_seen_d = 1'b1;
`endif

    busy_d = (state_d != S_IDLE);
  end

  assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_STRETCH_EN
  assign i2c_scl  = scl_oe_q ? 1'b0 : 1'bz;
`else
  assign i2c_scl  = 1'bz;
`endif

  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign RX_FIRST = rx_first_q;
  assign TX_REQ   = tx_req_q;
  assign STOP     = stop_pulse_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench with a bit-banged I2C initiator driving the
// target over pulled-up open-drain lines.
module tb_i2c_target;

  localparam int Q   = 40;
  localparam int FLT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #6 clk = ~clk;

  wire scl_w, sda_w;
  pullup (scl_w);
  pullup (sda_w);

  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  assign scl_w = m_scl_low ? 1'b0 : 1'bz;
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;

  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_FIRST, TX_REQ, STOP, busy;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_ACK  = 1'b0;

  i2c_target #(.ADDR(7'h20), .FILTER(FLT)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .i2c_scl(scl_w), .i2c_sda(sda_w),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_FIRST(RX_FIRST),
    .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_ACK(TX_ACK),
    .STOP(STOP), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Activity log and fabric-side responder.
  logic [8:0] rx_log [16];
  logic [7:0] tx_bytes [4];
  int rx_cnt = 0, tx_req_cnt = 0, stop_cnt = 0, sda_drv_cnt = 0;
  int tx_base = 0, ack_delay = 1, ack_timer = 0;

  always @(negedge clk) begin
    TX_ACK = 1'b0;
    if (ack_timer > 0) begin
      ack_timer--;
      if (ack_timer == 0) TX_ACK = 1'b1;
    end
    if (RX_VALID) begin
      rx_log[4'(rx_cnt)] = {RX_FIRST, RX_DATA};
      rx_cnt++;
    end
    if (TX_REQ) begin
      TX_DATA = tx_bytes[2'(tx_req_cnt - tx_base)];
      tx_req_cnt++;
      ack_timer = ack_delay;
    end
    if (STOP) stop_cnt++;
    if (sda_w === 1'b0 && !m_sda_low) sda_drv_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_scl_high();
    int i = 0;
    while (scl_w !== 1'b1 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    n_tests++;
    if (scl_w !== 1'b1) begin
      n_fail++;
      $display("FAIL scl_release_timeout: scl=%b want 1", scl_w);
    end
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda_low = ~b;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    r = sda_w;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic m_start();
    m_sda_low = 1'b0;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    m_sda_low = 1'b0;
    tick(Q);
  endtask

  task automatic m_write(input logic [7:0] d, output logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, nack);
  endtask

  task automatic m_read(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(~ack, r);
  endtask

  task automatic test_reset();
    tick(5);
    @(negedge clk);
    n_tests++; if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", RX_DATA); end
    n_tests++; if ({RX_VALID, RX_FIRST, TX_REQ, STOP, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 00000", {RX_VALID, RX_FIRST, TX_REQ, STOP, busy});
    end
    n_tests++; if ({scl_w, sda_w} !== 2'b11) begin n_fail++; $display("FAIL reset_lines: got %b want 11", {scl_w, sda_w}); end
    rst_n = 1'b1;
    tick(20);
  endtask

  task automatic test_write();
    logic n0, n1, n2;
    int rb, sb;
    rb = rx_cnt; sb = stop_cnt;
    m_start();
    m_write(8'h40, n0);
    m_write(8'hA5, n1);
    m_write(8'h5A, n2);
    m_stop();
    tick(20);
    @(negedge clk);
    n_tests++; if ({n0, n1, n2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got nack=%b want 000", {n0, n1, n2}); end
    n_tests++; if (rx_cnt - rb != 2) begin n_fail++; $display("FAIL write_rx_count: got %0d want 2", rx_cnt - rb); end
    n_tests++; if (rx_log[4'(rb)] !== 9'h1A5) begin n_fail++; $display("FAIL write_byte0: got %h want 1a5", rx_log[4'(rb)]); end
    n_tests++; if (rx_log[4'(rb + 1)] !== 9'h05A) begin n_fail++; $display("FAIL write_byte1: got %h want 05a", rx_log[4'(rb + 1)]); end
    n_tests++; if (stop_cnt - sb != 1) begin n_fail++; $display("FAIL write_stop: got %0d want 1", stop_cnt - sb); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic n0;
    logic [7:0] d0, d1;
    int tb;
    tx_bytes[0] = 8'h3C; tx_bytes[1] = 8'hC3; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h00;
    tx_base = tx_req_cnt; tb = tx_req_cnt;
    m_start();
    m_write(8'h41, n0);
    m_read(1'b1, d0);
    m_read(1'b0, d1);
    @(negedge clk);
    n_tests++; if (sda_w !== 1'b1) begin n_fail++; $display("FAIL read_sda_after_nack: got %b want 1", sda_w); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy_ignore: got %b want 1", busy); end
    m_stop();
    tick(10);
    n_tests++; if (n0 !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got nack=%b want 0", n0); end
    n_tests++; if (d0 !== 8'h3C) begin n_fail++; $display("FAIL read_byte0: got %h want 3c", d0); end
    n_tests++; if (d1 !== 8'hC3) begin n_fail++; $display("FAIL read_byte1: got %h want c3", d1); end
    n_tests++; if (tx_req_cnt - tb != 2) begin n_fail++; $display("FAIL read_tx_req_count: got %0d want 2", tx_req_cnt - tb); end
  endtask

  task automatic test_mismatch();
    logic n0, n1;
    int rb, tb, db;
    rb = rx_cnt; tb = tx_req_cnt; db = sda_drv_cnt;
    m_start();
    m_write(8'h42, n0);
    m_write(8'h00, n1);
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mismatch_busy_ignore: got %b want 1", busy); end
    m_stop();
    tick(20);
    @(negedge clk);
    n_tests++; if (n0 !== 1'b1) begin n_fail++; $display("FAIL mismatch_nack: got nack=%b want 1", n0); end
    n_tests++; if (sda_drv_cnt - db != 0) begin n_fail++; $display("FAIL mismatch_sda_driven: got %0d want 0", sda_drv_cnt - db); end
    n_tests++; if ((rx_cnt - rb) + (tx_req_cnt - tb) != 0) begin
      n_fail++; $display("FAIL mismatch_activity: got %0d want 0", (rx_cnt - rb) + (tx_req_cnt - tb));
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_repeated_start();
    logic n0, n1, r;
    logic [7:0] d;
    int rb, tb;
    tx_bytes[0] = 8'h69; tx_bytes[1] = 8'h00;
    tx_base = tx_req_cnt; rb = rx_cnt; tb = tx_req_cnt;
    m_start();
    m_write(8'h40, n0);
    m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b1, r);
    m_start();
    m_write(8'h41, n1);
    m_read(1'b0, d);
    m_stop();
    tick(10);
    n_tests++; if ({n0, n1} !== 2'b00) begin n_fail++; $display("FAIL rs_acks: got nack=%b want 00", {n0, n1}); end
    n_tests++; if (rx_cnt - rb != 0) begin n_fail++; $display("FAIL rs_partial_rx: got %0d want 0", rx_cnt - rb); end
    n_tests++; if (tx_req_cnt - tb != 1) begin n_fail++; $display("FAIL rs_tx_req: got %0d want 1", tx_req_cnt - tb); end
    n_tests++; if (d !== 8'h69) begin n_fail++; $display("FAIL rs_read_byte: got %h want 69", d); end
  endtask

  task automatic test_glitch();
    logic n0, n1, r;
    logic [7:0] v;
    int rb;
    v = 8'h3C; rb = rx_cnt;
    m_start();
    m_write(8'h40, n0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) begin
        m_sda_low = ~v[i];
        tick(Q);
        m_scl_low = 1'b0;
        wait_scl_high();
        tick(Q / 2);
        m_scl_low = 1'b1;
        tick(2);
        m_scl_low = 1'b0;
        tick(Q / 2);
        tick(Q);
        m_scl_low = 1'b1;
        tick(Q);
      end else begin
        m_bit(v[i], r);
      end
    end
    m_bit(1'b1, n1);
    m_stop();
    tick(10);
    n_tests++; if ({n0, n1} !== 2'b00) begin n_fail++; $display("FAIL glitch_acks: got nack=%b want 00", {n0, n1}); end
    n_tests++; if (rx_cnt - rb != 1) begin n_fail++; $display("FAIL glitch_rx_count: got %0d want 1", rx_cnt - rb); end
    n_tests++; if (rx_log[4'(rb)] !== 9'h13C) begin n_fail++; $display("FAIL glitch_byte: got %h want 13c", rx_log[4'(rb)]); end
  endtask

  task automatic test_reset_mid();
    logic r;
    logic [7:0] a;
    a = 8'h40;
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(a[i], r);
    m_sda_low = 1'b0;
    tick(Q);
    m_scl_low = 1'b0;
    wait_scl_high();
    tick(Q);
    @(negedge clk);
    n_tests++; if (sda_w !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_driven: got %b want 0", sda_w); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({scl_w, sda_w} !== 2'b11) begin n_fail++; $display("FAIL rstmid_lines: got %b want 11", {scl_w, sda_w}); end
    n_tests++; if ({RX_DATA, RX_VALID, RX_FIRST, TX_REQ, STOP, busy} !== 13'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0000", {RX_DATA, RX_VALID, RX_FIRST, TX_REQ, STOP, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(Q);
    m_scl_low = 1'b1;
    tick(Q);
    m_stop();
    tick(20);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
  endtask

`ifdef I2C_TARGET_STRETCH_EN
  task automatic test_stretch();
    logic n0;
    logic [7:0] d;
    int k;
    tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h00;
    tx_base = tx_req_cnt;
    ack_delay = 500;
    fork
      begin
        m_start();
        m_write(8'h41, n0);
        m_read(1'b0, d);
        m_stop();
      end
      begin
        k = 0;
        while (TX_ACK !== 1'b1 && k < 20000) begin @(posedge clk); #1; k++; end
        n_tests++; if (scl_w !== 1'b0) begin n_fail++; $display("FAIL stretch_scl_held: got %b want 0", scl_w); end
        k = 0;
        while (scl_w !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
        n_tests++; if (k < FLT + 1 || k > FLT + 3) begin
          n_fail++; $display("FAIL stretch_release_delay: got %0d want %0d", k, FLT + 2);
        end
      end
    join
    ack_delay = 1;
    tick(10);
    n_tests++; if (n0 !== 1'b0) begin n_fail++; $display("FAIL stretch_addr_ack: got nack=%b want 0", n0); end
    n_tests++; if (d !== 8'h96) begin n_fail++; $display("FAIL stretch_byte: got %h want 96", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_glitch();
    test_reset_mid();
`ifdef I2C_TARGET_STRETCH_EN
    test_stretch();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
